lda_result_tx: RTL

//  Transmit side for LDA results: captures the six sign/exponent/mantissa results (ev1, ev2, v1x, v2x, v1y, v2y)

---
 rtl/lda_result_tx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lda_result_tx.sv
// Frames the six LDA results (sign/exponent/mantissa) into a 32-byte stream:
// header, 5 bytes per result, then an XOR checksum of the payload, on a valid/ready byte link.
module lda_result_tx #(
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         NUM_RES  = 6,
    parameter int         MANT_W   = 24,
    parameter int         EXP_W    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [NUM_RES-1:0]        res_sign_i,
    input  logic [EXP_W*NUM_RES-1:0]  res_exp_i,
    input  logic [MANT_W*NUM_RES-1:0] res_mant_i,
    output logic [7:0]                tx_data_o,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i,
    output logic                      tx_last_o,
    output logic                      busy_o,
    output logic                      drop_o
);

    localparam int         FRAME_LEN = 2 + 5 * NUM_RES;
    localparam logic [4:0] IDX_LAST  = 5'(FRAME_LEN - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [NUM_RES-1:0]        sign_q, sign_d;
    logic [EXP_W*NUM_RES-1:0]  exp_q, exp_d;
    logic [MANT_W*NUM_RES-1:0] mant_q, mant_d;
    logic [4:0]                idx_q, idx_d;
    logic [2:0]                res_q, res_d;
    logic [2:0]                fld_q, fld_d;
    logic [7:0]                chk_q, chk_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      tx_last_q, tx_last_d;
    logic                      drop_q, drop_d;
    logic                      accept_s;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Field f of result r from the shadow bank: {7'b0,sign}, exp, mant MSB..LSB.
    function automatic logic [7:0] field_byte(
        input logic [NUM_RES-1:0]        s,
        input logic [EXP_W*NUM_RES-1:0]  e,
        input logic [MANT_W*NUM_RES-1:0] m,
        input logic [2:0]                r,
        input logic [2:0]                f
    );
        logic              sb;
        logic [EXP_W-1:0]  eb;
        logic [MANT_W-1:0] mb;
        logic [7:0]        b;
        sb = 1'b0;
        eb = '0;
        mb = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            if (r == 3'(i)) begin
                sb = s[i];
                eb = e[EXP_W*i +: EXP_W];
                mb = m[MANT_W*i +: MANT_W];
            end else begin
                sb = sb;
            end
        end
        case (f)
            3'd0:    b = {7'b0000000, sb};
            3'd1:    b = eb[7:0];
            3'd2:    b = mb[23:16];
            3'd3:    b = mb[15:8];
            3'd4:    b = mb[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign accept_s    = tx_valid_q & tx_ready_i;
    assign res_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == SEND);
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_last_o   = tx_last_q;
    assign drop_o      = drop_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sign_q     <= '0;
            exp_q      <= '0;
            mant_q     <= '0;
            idx_q      <= 5'd0;
            res_q      <= 3'd0;
            fld_q      <= 3'd0;
            chk_q      <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            fld_q      <= fld_d;
            chk_q      <= chk_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (res_valid_i) state_d = SEND;
                else             state_d = IDLE;
            end
            SEND: begin
                if (accept_s && (idx_q == IDX_LAST)) state_d = IDLE;
                else                                 state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture, byte sequencing and checksum accumulation.
    always_comb begin
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        idx_d      = idx_q;
        res_d      = res_q;
        fld_d      = fld_q;
        chk_d      = chk_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        drop_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (res_valid_i) begin
                    sign_d     = res_sign_i;
                    exp_d      = res_exp_i;
                    mant_d     = res_mant_i;
                    idx_d      = 5'd0;
                    res_d      = 3'd0;
                    fld_d      = 3'd0;
                    chk_d      = 8'h00;
                    tx_data_d  = HDR_BYTE;
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                end else begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                end
            end
            SEND: begin
                drop_d = res_valid_i;
                if (accept_s && (idx_q == IDX_LAST)) begin
                    idx_d      = 5'd0;
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                end else if (accept_s) begin
                    idx_d = idx_q + 5'd1;
                    // The header is not part of the checksum.
                    if (idx_q == 5'd0) begin
                        chk_d = chk_q;
                        res_d = 3'd0;
                        fld_d = 3'd0;
                    end else if (fld_q == 3'd4) begin
                        chk_d = chk_fold(chk_q, tx_data_q);
                        res_d = res_q + 3'd1;
                        fld_d = 3'd0;
                    end else begin
                        chk_d = chk_fold(chk_q, tx_data_q);
                        res_d = res_q;
                        fld_d = fld_q + 3'd1;
                    end
                    if (idx_q == IDX_LAST - 5'd1) begin
                        tx_data_d = chk_d;
                        tx_last_d = 1'b1;
                    end else begin
                        tx_data_d = field_byte(sign_q, exp_q, mant_q, res_d, fld_d);
                        tx_last_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        endcase
    end

endmodule
